deco_seq_nx: RTL

Parametrised registered decoder and one-hot timing-state sequencer for the 19-bit CPU control path. In direct mode it registers a binary select and drives the matching one-hot line, generalising the 2-to-4 decoder to any SEL_W. In sequence mode it runs free through indices 0..LAST and emits one-hot T-state strobes for the control unit. Stall/hold, programmable wrap point and a wrap pulse are added.

---
 rtl/deco_seq_nx.sv | 53 +++++
 1 files changed

// File: rtl/deco_seq_nx.sv
// deco_seq_nx: registered binary-to-one-hot decoder with a free-running T-state sequencer
// (stall/hold, programmable wrap point, wrap pulse).
module deco_seq_nx #(
  parameter int SEL_W = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         select,
  input  logic                     load,
  input  logic [SEL_W-1:0]         last,
  input  logic                     stall,
  output logic [(1<<SEL_W)-1:0]    decoded_op,
  output logic [SEL_W-1:0]         cur_idx,
  output logic                     valid,
  output logic                     wrap
);
  localparam int OUT_W = 1 << SEL_W;
  typedef enum logic [1:0] {IDLE, DIRECT, RUN, HOLD} state_t;
  state_t state, state_nxt;
  logic load_hit, at_last, wrap_nxt;
  logic [SEL_W-1:0] idx_nxt;
  assign load_hit = en && mode && load;
  assign at_last  = cur_idx == last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      cur_idx    <= '0;
      decoded_op <= '0;
      valid      <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_idx    <= idx_nxt;
      decoded_op <= (state_nxt != IDLE) ? OUT_W'(1) << idx_nxt : '0;
      valid      <= state_nxt != IDLE;
      wrap       <= wrap_nxt;
    end
  always_comb
    state_nxt = !en ? IDLE :
                load_hit ? RUN :
                !mode ? DIRECT :
                (state == RUN || state == HOLD) ? (stall ? HOLD : RUN) : IDLE;
  // RUN without load_hit means an advance from RUN/HOLD; only that path may pulse wrap
  always_comb begin
    idx_nxt  = (state_nxt == IDLE) ? '0 :
               (state_nxt == DIRECT || load_hit) ? select :
               (state_nxt == HOLD) ? cur_idx :
               at_last ? '0 : SEL_W'(cur_idx + 1'b1);
    wrap_nxt = state_nxt == RUN && !load_hit && at_last;
  end
endmodule
